// File: rtl/bp_me_axi_pump_pkg.sv
// Shared types, constants and helper macros for the AXI burst pump.
// The optional 4KB-crossing check is enabled with BP_ME_AXI_PUMP_4K_CHECK_EN.
`ifndef BSG_SAFE_CLOG2
`define BSG_SAFE_CLOG2(x) (((x) == 1) ? 1 : $clog2(x))
`endif

`ifndef declare_bp_me_axi_txn_S
`define declare_bp_me_axi_txn_S(addr_width_mp) \
    typedef struct packed { \
        logic [addr_width_mp-1:0] addr; \
        axi_burst_e               burst; \
        logic [7:0]               len; \
        logic [2:0]               size; \
    } axi_txn_s
`endif

package bp_me_axi_pump_pkg;

    typedef enum logic [1:0] {
        e_fixed = 2'd0,
        e_incr  = 2'd1,
        e_wrap  = 2'd2,
        e_rsvd  = 2'd3
    } axi_burst_e;

    localparam int axi_4k_page_lg_gp = 12;

    function automatic logic wrap_len_ok(input logic [7:0] len);
        return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    endfunction

endpackage

// File: rtl/bp_me_axi_beat_gen.sv
// Combinational AXI beat math: next beat address, byte-lane strobe and protocol error.
// With BP_ME_AXI_PUMP_4K_CHECK_EN defined, INCR bursts leaving their 4KB page also flag err_o.
module bp_me_axi_beat_gen
    import bp_me_axi_pump_pkg::*;
#(
    parameter  int axi_addr_width_p     = 64,
    parameter  int axi_data_width_p     = 64,
    localparam int mask_width_lp        = axi_data_width_p / 8,
    localparam int lg_axi_mask_width_lp = `BSG_SAFE_CLOG2(mask_width_lp)
) (
    input  logic [axi_addr_width_p-1:0] addr_i,
    input  logic [axi_addr_width_p-1:0] start_addr_i,
    input  axi_burst_e                  burst_i,
    input  logic [7:0]                  len_i,
    input  logic [2:0]                  size_i,
    output logic [axi_addr_width_p-1:0] next_addr_o,
    output logic [mask_width_lp-1:0]    mask_o,
    output logic                        err_o
);
    localparam int          aw_lp         = axi_addr_width_p;
    localparam logic [2:0]  max_size_lp   = 3'(lg_axi_mask_width_lp);

    axi_burst_e       eff_burst;
    logic             len_ok, start_unaligned, page_err;
    logic [aw_lp-1:0] nb, aligned, incr_addr, dtsize, wrap_lower;
    logic [2:0]       mask_size;
    logic [aw_lp-1:0] mask_nb, mask_aligned, lane_lo, lane_hi;
`ifdef BP_ME_AXI_PUMP_4K_CHECK_EN
    logic [aw_lp-1:0] final_addr;
`endif

    always_comb begin
        len_ok    = wrap_len_ok(len_i);
        eff_burst = burst_i;
        if (burst_i == e_rsvd) eff_burst = e_fixed;
        else if ((burst_i == e_wrap) && !len_ok) eff_burst = e_incr;

        nb         = aw_lp'(1) << size_i;
        aligned    = addr_i & ~(nb - aw_lp'(1));
        incr_addr  = aligned + nb;
        dtsize     = (aw_lp'(len_i) + aw_lp'(1)) << size_i;
        wrap_lower = start_addr_i & ~(dtsize - aw_lp'(1));

        // Distance test stays correct when the wrap window touches the top of the address space.
        case (eff_burst)
            e_incr:  next_addr_o = incr_addr;
            e_wrap:  next_addr_o = ((incr_addr - wrap_lower) >= dtsize) ? wrap_lower : incr_addr;
            default: next_addr_o = addr_i;
        endcase

        mask_size    = (size_i > max_size_lp) ? max_size_lp : size_i;
        mask_nb      = aw_lp'(1) << mask_size;
        mask_aligned = addr_i & ~(mask_nb - aw_lp'(1));
        lane_lo      = addr_i & aw_lp'(mask_width_lp - 1);
        lane_hi      = (mask_aligned + mask_nb - aw_lp'(1)) & aw_lp'(mask_width_lp - 1);
        mask_o       = '0;
        for (int i = 0; i < mask_width_lp; i++) begin
            mask_o[i] = (aw_lp'(i) >= lane_lo) && (aw_lp'(i) <= lane_hi);
        end

        start_unaligned = |(start_addr_i & (nb - aw_lp'(1)));
`ifdef BP_ME_AXI_PUMP_4K_CHECK_EN
        final_addr = (len_i == 8'd0) ? start_addr_i
                   : (start_addr_i & ~(nb - aw_lp'(1))) + (aw_lp'(len_i) << size_i);
        page_err   = (eff_burst == e_incr)
                   && ((final_addr >> axi_4k_page_lg_gp) != (start_addr_i >> axi_4k_page_lg_gp));
`else
        page_err   = 1'b0;
`endif

        err_o = (burst_i == e_rsvd)
              | ((burst_i == e_wrap) & ~len_ok)
              | ((burst_i == e_wrap) & start_unaligned)
              | (size_i > max_size_lp)
              | page_err;
    end

endmodule

// File: rtl/bsg_fifo_1r1w_small.sv
// Small circular-buffer FIFO, one write and one read port, asynchronous active-high reset.
// v_i is only honoured while ready_o is high; yumi_i is only legal while v_o is high.
module bsg_fifo_1r1w_small #(
    parameter int width_p = 8,
    parameter int els_p   = 2
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               v_i,
    output logic               ready_o,
    input  logic [width_p-1:0] data_i,
    output logic               v_o,
    output logic [width_p-1:0] data_o,
    input  logic               yumi_i
);
    localparam int ptr_w_lp = `BSG_SAFE_CLOG2(els_p);
    localparam int cnt_w_lp = $clog2(els_p + 1);

    logic [width_p-1:0]  mem_q [els_p];
    logic [ptr_w_lp-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [cnt_w_lp-1:0] cnt_q, cnt_d;
    logic                enq, deq;

    assign ready_o = (cnt_q != cnt_w_lp'(els_p));
    assign v_o     = (cnt_q != '0);
    assign data_o  = mem_q[rptr_q];
    assign enq     = v_i & ready_o;
    assign deq     = yumi_i & v_o;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (enq) wptr_d = (wptr_q == ptr_w_lp'(els_p - 1)) ? '0 : wptr_q + ptr_w_lp'(1);
        if (deq) rptr_d = (rptr_q == ptr_w_lp'(els_p - 1)) ? '0 : rptr_q + ptr_w_lp'(1);
        if (enq && !deq) cnt_d = cnt_q + cnt_w_lp'(1);
        if (deq && !enq) cnt_d = cnt_q - cnt_w_lp'(1);
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    // Storage carries no reset; it is only observed behind v_o.
    always_ff @(posedge clk_i) begin
        if (enq) mem_q[wptr_q] <= data_i;
    end

endmodule

// File: rtl/bp_me_axi_burst_pump.sv
// AXI burst beat generator: queues AR/AW transactions and streams one beat per yumi_i.
// Optional 4KB-crossing error check is enabled with BP_ME_AXI_PUMP_4K_CHECK_EN.
module bp_me_axi_burst_pump
    import bp_me_axi_pump_pkg::*;
#(
    parameter  int axi_addr_width_p = 64,
    parameter  int axi_data_width_p = 64,
    parameter  int els_p            = 2,
    localparam int mask_width_lp    = axi_data_width_p / 8
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic                        v_i,
    output logic                        ready_and_o,
    input  logic [axi_addr_width_p-1:0] axaddr_i,
    input  logic [1:0]                  axburst_i,
    input  logic [7:0]                  axlen_i,
    input  logic [2:0]                  axsize_i,
    output logic                        v_o,
    input  logic                        yumi_i,
    output logic [axi_addr_width_p-1:0] addr_o,
    output logic [mask_width_lp-1:0]    mask_o,
    output logic [2:0]                  size_o,
    output logic [7:0]                  len_o,
    output logic [7:0]                  beat_o,
    output logic                        first_o,
    output logic                        last_o,
    output logic                        err_o
);
    `declare_bp_me_axi_txn_S(axi_addr_width_p);

    axi_txn_s                    txn_li, head_lo;
    logic                        fifo_ready_lo, fifo_v_lo;
    logic [7:0]                  beat_q, beat_d;
    logic [axi_addr_width_p-1:0] addr_q, addr_d, next_addr_lo;

    always_comb begin
        txn_li.addr  = axaddr_i;
        txn_li.burst = axi_burst_e'(axburst_i);
        txn_li.len   = axlen_i;
        txn_li.size  = axsize_i;
    end

    // Handshakes: a transaction transfers on v_i & ready_and_o; a beat transfers on v_o & yumi_i.
    // ready_and_o reflects only queue-not-full (held low during reset), never yumi_i.
    assign ready_and_o = fifo_ready_lo & ~reset_i;

    bsg_fifo_1r1w_small #(
        .width_p ($bits(axi_txn_s)),
        .els_p   (els_p)
    ) txn_fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .v_i     (v_i & ready_and_o),
        .ready_o (fifo_ready_lo),
        .data_i  (txn_li),
        .v_o     (fifo_v_lo),
        .data_o  (head_lo),
        .yumi_i  (yumi_i & last_o & fifo_v_lo)
    );

    assign v_o     = fifo_v_lo;
    assign beat_o  = beat_q;
    assign first_o = (beat_q == 8'd0);
    assign last_o  = (beat_q == head_lo.len);
    assign size_o  = head_lo.size;
    assign len_o   = head_lo.len;
    assign addr_o  = first_o ? head_lo.addr : addr_q;

    bp_me_axi_beat_gen #(
        .axi_addr_width_p (axi_addr_width_p),
        .axi_data_width_p (axi_data_width_p)
    ) beat_gen (
        .addr_i       (addr_o),
        .start_addr_i (head_lo.addr),
        .burst_i      (head_lo.burst),
        .len_i        (head_lo.len),
        .size_i       (head_lo.size),
        .next_addr_o  (next_addr_lo),
        .mask_o       (mask_o),
        .err_o        (err_o)
    );

    always_comb begin
        beat_d = beat_q;
        addr_d = addr_q;
        if (yumi_i && fifo_v_lo) begin
            if (last_o) begin
                beat_d = 8'd0;
            end else begin
                beat_d = beat_q + 8'd1;
                addr_d = next_addr_lo;
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            beat_q <= 8'd0;
            addr_q <= '0;
        end else begin
            beat_q <= beat_d;
            addr_q <= addr_d;
        end
    end

endmodule

// File: tb/tb_bp_me_axi_burst_pump.sv
// Self-checking bench for bp_me_axi_burst_pump (64-bit address, 64-bit data, els_p=2).
// The beat model expands each accepted transaction into its full beat list in closed form.
`timescale 1ns/1ps
module tb_bp_me_axi_burst_pump;

    localparam int els_lp = 2;

    logic        clk_i     = 1'b0;
    logic        reset_i   = 1'b1;
    logic        v_i       = 1'b0;
    logic        yumi_i    = 1'b0;
    logic [63:0] axaddr_i  = '0;
    logic [1:0]  axburst_i = '0;
    logic [7:0]  axlen_i   = '0;
    logic [2:0]  axsize_i  = '0;
    logic        ready_and_o, v_o, first_o, last_o, err_o;
    logic [63:0] addr_o;
    logic [7:0]  mask_o, len_o, beat_o;
    logic [2:0]  size_o;

    bp_me_axi_burst_pump #(
        .axi_addr_width_p (64),
        .axi_data_width_p (64),
        .els_p            (els_lp)
    ) dut (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .v_i         (v_i),
        .ready_and_o (ready_and_o),
        .axaddr_i    (axaddr_i),
        .axburst_i   (axburst_i),
        .axlen_i     (axlen_i),
        .axsize_i    (axsize_i),
        .v_o         (v_o),
        .yumi_i      (yumi_i),
        .addr_o      (addr_o),
        .mask_o      (mask_o),
        .size_o      (size_o),
        .len_o       (len_o),
        .beat_o      (beat_o),
        .first_o     (first_o),
        .last_o      (last_o),
        .err_o       (err_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [63:0] addr;
        logic [7:0]  mask;
        logic [7:0]  beat;
        logic        first;
        logic        last;
        logic        err;
        logic [2:0]  size;
        logic [7:0]  len;
    } beat_t;

    beat_t exp_q[$];
    int    n_txn    = 0;
    int    errors   = 0;
    int    checks   = 0;
    int    run_cnt  = 0;
    int    last_run = 0;
    int    run_id   = 0;
    int    rdy_low  = 0;
    logic  yumi_all = 1'b0;

    // ---------------- reference model ----------------
    function automatic logic len_pow2(input logic [7:0] l);
        return (l == 8'd1) || (l == 8'd3) || (l == 8'd7) || (l == 8'd15);
    endfunction

    function automatic logic [1:0] m_eff(input logic [1:0] b, input logic [7:0] l);
        if (b == 2'd3) return 2'd0;
        if (b == 2'd2 && !len_pow2(l)) return 2'd1;
        return b;
    endfunction

    function automatic logic [63:0] m_addr(input logic [63:0] a, input logic [1:0] b,
                                           input logic [7:0] l, input logic [2:0] s, input int k);
        logic [63:0] nb, al, dt, lo, step;
        nb   = 64'd1 << s;
        al   = a & ~(nb - 64'd1);
        step = 64'(k) << s;
        if (k == 0) return a;
        case (m_eff(b, l))
            2'd1: return al + step;
            2'd2: begin
                dt = (64'(l) + 64'd1) << s;
                lo = a & ~(dt - 64'd1);
                return lo + ((al - lo + step) % dt);
            end
            default: return a;
        endcase
    endfunction

    function automatic logic [7:0] m_mask(input logic [63:0] a, input logic [2:0] s);
        logic [2:0]  sc;
        logic [63:0] nb;
        int          lo, hi;
        logic [7:0]  m;
        sc = (s > 3'd3) ? 3'd3 : s;
        nb = 64'd1 << sc;
        lo = int'(a % 64'd8);
        hi = int'(((a & ~(nb - 64'd1)) + nb - 64'd1) % 64'd8);
        m  = '0;
        for (int i = lo; i <= hi; i++) m[i] = 1'b1;
        return m;
    endfunction

    function automatic logic m_err(input logic [63:0] a, input logic [1:0] b,
                                   input logic [7:0] l, input logic [2:0] s);
        logic e;
        e = (b == 2'd3) || (b == 2'd2 && !len_pow2(l))
         || (b == 2'd2 && ((a % (64'd1 << s)) != 64'd0)) || (s > 3'd3);
`ifdef BP_ME_AXI_PUMP_4K_CHECK_EN
        if (m_eff(b, l) == 2'd1 && (m_addr(a, b, l, s, int'(l)) / 64'd4096) != (a / 64'd4096))
            e = 1'b1;
`endif
        return e;
    endfunction

    task automatic add_txn(input logic [63:0] a, input logic [1:0] b,
                           input logic [7:0] l, input logic [2:0] s);
        beat_t e;
        for (int k = 0; k <= int'(l); k++) begin
            e.addr  = m_addr(a, b, l, s, k);
            e.mask  = m_mask(e.addr, s);
            e.beat  = 8'(k);
            e.first = (k == 0);
            e.last  = (k == int'(l));
            e.err   = m_err(a, b, l, s);
            e.size  = s;
            e.len   = l;
            exp_q.push_back(e);
        end
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- per-cycle compare ----------------
    initial begin
        beat_t e;
        forever begin
            @(negedge clk_i);
            if (reset_i) begin
                chk("rst_v_o", 64'(v_o), 64'd0);
                chk("rst_ready", 64'(ready_and_o), 64'd0);
                exp_q.delete();
                n_txn   = 0;
                run_cnt = 0;
            end else begin
                chk("ready_and_o", 64'(ready_and_o), 64'(n_txn < els_lp));
                chk("v_o", 64'(v_o), 64'(exp_q.size() != 0));
                if (v_o && exp_q.size() != 0) begin
                    e = exp_q[0];
                    chk("addr_o",  addr_o,         e.addr);
                    chk("mask_o",  64'(mask_o),    64'(e.mask));
                    chk("beat_o",  64'(beat_o),    64'(e.beat));
                    chk("first_o", 64'(first_o),   64'(e.first));
                    chk("last_o",  64'(last_o),    64'(e.last));
                    chk("err_o",   64'(err_o),     64'(e.err));
                    chk("size_o",  64'(size_o),    64'(e.size));
                    chk("len_o",   64'(len_o),     64'(e.len));
                end
                if (v_o) run_cnt++;
                else begin
                    if (run_cnt != 0) begin
                        last_run = run_cnt;
                        run_id++;
                    end
                    run_cnt = 0;
                end
                if (!ready_and_o) rdy_low++;
                if (v_o && yumi_i && exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    if (e.last) n_txn--;
                end
                if (v_i && ready_and_o) begin
                    add_txn(axaddr_i, axburst_i, axlen_i, axsize_i);
                    n_txn++;
                end
            end
        end
    end

    // Consumer: yumi only while v_o, either always or ~70% of cycles.
    initial begin
        forever begin
            @(posedge clk_i);
            #1;
            yumi_i = v_o & (yumi_all | ($urandom_range(0, 99) < 70));
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    task automatic drive_txn(input logic [63:0] a, input logic [1:0] b,
                             input logic [7:0] l, input logic [2:0] s);
        int waited;
        waited    = 0;
        v_i       = 1'b1;
        axaddr_i  = a;
        axburst_i = b;
        axlen_i   = l;
        axsize_i  = s;
        @(negedge clk_i);
        while (!ready_and_o && waited < 2000) begin
            @(negedge clk_i);
            waited++;
        end
        chk("accept_in_time", 64'(waited < 2000), 64'd1);
        @(posedge clk_i);
        #1;
        v_i = 1'b0;
    endtask

    task automatic drain();
        int waited;
        waited = 0;
        while ((exp_q.size() != 0 || v_o) && waited < 5000) begin
            @(negedge clk_i);
            waited++;
        end
        chk("drain_in_time", 64'(waited < 5000), 64'd1);
        repeat (2) @(posedge clk_i);
        #1;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int          rdy0, run0, waited;
        logic [63:0] ra;
        logic [2:0]  rs;
        logic [7:0]  rl;

        // Hand-computed values pinning the model.
        chk("pin_incr_a1", m_addr(64'h1004, 2'd1, 8'd3, 3'd2, 1), 64'h1008);
        chk("pin_incr_a2", m_addr(64'h1004, 2'd1, 8'd3, 3'd2, 2), 64'h100C);
        chk("pin_incr_a3", m_addr(64'h1004, 2'd1, 8'd3, 3'd2, 3), 64'h1010);
        chk("pin_incr_m0", 64'(m_mask(64'h1004, 3'd2)), 64'hF0);
        chk("pin_incr_m1", 64'(m_mask(64'h1008, 3'd2)), 64'h0F);
        chk("pin_wrap_a1", m_addr(64'h1038, 2'd2, 8'd3, 3'd3, 1), 64'h1020);
        chk("pin_wrap_a3", m_addr(64'h1038, 2'd2, 8'd3, 3'd3, 3), 64'h1030);
        chk("pin_wrap_m",  64'(m_mask(64'h1038, 3'd3)), 64'hFF);
        chk("pin_wrap_e",  64'(m_err(64'h1038, 2'd2, 8'd3, 3'd3)), 64'd0);
        chk("pin_fix_a1",  m_addr(64'h2003, 2'd0, 8'd1, 3'd1, 1), 64'h2003);
        chk("pin_fix_m",   64'(m_mask(64'h2003, 3'd1)), 64'h08);
        chk("pin_rsvd_e",  64'(m_err(64'h2003, 2'd3, 8'd1, 3'd1)), 64'd1);
        chk("pin_4k_a1",   m_addr(64'hFF8, 2'd1, 8'd1, 3'd3, 1), 64'h1000);
`ifdef BP_ME_AXI_PUMP_4K_CHECK_EN
        chk("pin_4k_e",    64'(m_err(64'hFF8, 2'd1, 8'd1, 3'd3)), 64'd1);
`else
        chk("pin_4k_e",    64'(m_err(64'hFF8, 2'd1, 8'd1, 3'd3)), 64'd0);
`endif

        // Reset: held for a few cycles, then released just after a rising edge.
        repeat (3) @(posedge clk_i);
        #1;
        reset_i = 1'b0;
        @(negedge clk_i);
        chk("post_rst_ready", 64'(ready_and_o), 64'd1);
        chk("post_rst_v_o",   64'(v_o), 64'd0);
        @(posedge clk_i);
        #1;

        // Directed bursts (plan items 1-3, plus a full 256-beat INCR).
        drive_txn(64'h1004, 2'd1, 8'd3, 3'd2);
        drive_txn(64'h1038, 2'd2, 8'd3, 3'd3);
        drive_txn(64'h2003, 2'd0, 8'd1, 3'd1);
        drive_txn(64'h2003, 2'd3, 8'd1, 3'd1);
        drive_txn(64'h1034, 2'd2, 8'd5, 3'd2);
        drive_txn(64'h1030, 2'd2, 8'd3, 3'd5);
        drive_txn(64'h1000, 2'd1, 8'd255, 3'd3);
        drive_txn(64'hFF8, 2'd1, 8'd1, 3'd3);
        drive_txn(64'hFFFF_FFFF_FFFF_FFF0, 2'd1, 8'd3, 3'd3);
        drain();

        // Zero-bubble streaming of two single-beat bursts.
        yumi_all = 1'b1;
        rdy0 = rdy_low;
        run0 = run_id;
        drive_txn(64'h3000, 2'd1, 8'd0, 3'd3);
        drive_txn(64'h3008, 2'd1, 8'd0, 3'd3);
        repeat (3) @(posedge clk_i);
        #1;
        chk("b2b_run_len",     64'(last_run), 64'd2);
        chk("b2b_one_run",     64'(run_id - run0), 64'd1);
        chk("b2b_ready_stays", 64'(rdy_low - rdy0), 64'd0);

        // Asynchronous reset mid-burst with another burst queued.
        drive_txn(64'h4000, 2'd1, 8'd7, 3'd3);
        drive_txn(64'h5000, 2'd1, 8'd3, 3'd3);
        waited = 0;
        @(negedge clk_i);
        while (!(v_o && beat_o == 8'd2) && waited < 100) begin
            @(negedge clk_i);
            waited++;
        end
        chk("reach_beat2", 64'(waited < 100), 64'd1);
        #1;
        reset_i = 1'b1;
        #1;
        chk("async_rst_v_o",   64'(v_o), 64'd0);
        chk("async_rst_ready", 64'(ready_and_o), 64'd0);
        repeat (2) @(posedge clk_i);
        #1;
        reset_i = 1'b0;
        @(negedge clk_i);
        chk("rel_ready", 64'(ready_and_o), 64'd1);
        chk("rel_empty", 64'(v_o), 64'd0);
        @(posedge clk_i);
        #1;

        // Randomized traffic with a random consumer.
        yumi_all = 1'b0;
        for (int n = 0; n < 80; n++) begin
            ra = {32'($urandom), 32'($urandom)};
            if ($urandom_range(0, 3) == 0) ra = ra & 64'hFFF;
            rs = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
            case ($urandom_range(0, 3))
                0:       rl = 8'd0;
                1:       rl = 8'((1 << $urandom_range(1, 4)) - 1);
                default: rl = 8'($urandom_range(0, 9));
            endcase
            drive_txn(ra, 2'($urandom_range(0, 3)), rl, rs);
            repeat ($urandom_range(0, 2)) @(posedge clk_i);
            #0;
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
